// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage load/store engine.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned STRB_W = 4;

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and RAM valid/ready bus of the memory-stage engine.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 32
);
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              select;
  logic              misalign;
  logic              bus_err;
  logic              mem_valid;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, select, misalign, bus_err,
           mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output stall, rsp_valid, rsp_rdata, select, misalign, bus_err,
           mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replication, load extraction/extension,
// and misalignment / illegal funct3 detection.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              write,
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misalign,
  output logic              illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{lane, 3'b000} +: 8];
  assign half_sel = rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    wstrb     = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_B: begin
        wstrb     = 4'b0001 << lane;
        wdata_rep = {(DATA_W/8){wdata[7:0]}};
        rdata_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        wstrb     = 4'b0011 << {lane[1], 1'b0};
        wdata_rep = {(DATA_W/16){wdata[15:0]}};
        rdata_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misalign  = lane[0];
      end
      F3_W: begin
        wstrb     = '1;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = |lane;
      end
      F3_BU: begin
        rdata_ext = {{(DATA_W-8){1'b0}}, byte_sel};
        illegal   = write;
      end
      F3_HU: begin
        rdata_ext = {{(DATA_W-16){1'b0}}, half_sel};
        misalign  = lane[0];
        illegal   = write;
      end
      default: illegal = 1'b1;
    endcase
    if (!write) wstrb = '0;
    // an illegal code reports bus_err only, never misalign as well
    if (illegal) misalign = 1'b0;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: request capture, RAM valid/ready FSM,
// timeout and one-cycle response toward the MEM/WB register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              misalign_q;
  logic              bus_err_q;

  logic              al_write;
  logic [2:0]        al_f3;
  logic [1:0]        al_lane;
  logic [STRB_W-1:0] al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_misalign;
  logic              al_illegal;
  logic              timeout_hit;

  // one aligner serves both the IDLE check and the BUSY load extraction
  assign al_write    = (state == IDLE) ? bus.req_write         : we_q;
  assign al_f3       = (state == IDLE) ? bus.req_funct3        : f3_q;
  assign al_lane     = (state == IDLE) ? bus.req_addr[1:0]     : lane_q;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .write     (al_write),
    .funct3    (al_f3),
    .lane      (al_lane),
    .wdata     (bus.req_wdata),
    .rdata     (bus.mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign),
    .illegal   (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = (al_misalign || al_illegal) ? RESP : BUSY;
      BUSY:    if (bus.mem_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      lane_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req_valid) begin
            we_q       <= bus.req_write;
            f3_q       <= bus.req_funct3;
            lane_q     <= bus.req_addr[1:0];
            addr_q     <= {bus.req_addr[DATA_W-1:2], 2'b00};
            wdata_q    <= al_wdata;
            wstrb_q    <= al_wstrb;
            rdata_q    <= '0;
            misalign_q <= al_misalign;
            bus_err_q  <= al_illegal;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            if (!we_q) rdata_q <= al_rdata;
          end else if (timeout_hit) begin
            bus_err_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall     = ((state == IDLE) && bus.req_valid) || (state == BUSY);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
  assign bus.misalign  = bus.rsp_valid && misalign_q;
  assign bus.bus_err   = bus.rsp_valid && bus_err_q;
  assign bus.select    = bus.rsp_valid && !we_q && !misalign_q && !bus_err_q;
  assign bus.mem_valid = (state == BUSY);
  assign bus.mem_we    = (state == BUSY) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(DW)) bus ();

  mem_access_unit #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          obs_busy, obs_stall, obs_lat, obs_unstable;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_strb;
  logic        obs_we, obs_sel, obs_mis, obs_berr;

  // Drives one request at posedge+1, acts as RAM (mem_ready in BUSY cycle
  // number ready_cyc, 0 = never) and records what the DUT presented.
  task automatic run_req(input string name, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rword, input int ready_cyc);
    logic got_rsp;
    logic first;
    obs_busy = 0; obs_stall = 0; obs_lat = 0; obs_unstable = 0;
    obs_rdata = '0; obs_addr = '0; obs_wdata = '0; obs_strb = '0;
    obs_we = 0; obs_sel = 0; obs_mis = 0; obs_berr = 0;
    got_rsp = 0; first = 1;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = rword;
    #1;
    if (bus.stall) obs_stall++;
    if (bus.mem_valid) obs_busy++;
    for (int k = 1; k <= 20 && !got_rsp; k++) begin
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      #1;
      if (bus.stall) obs_stall++;
      if (bus.rsp_valid) begin
        got_rsp   = 1;
        obs_lat   = k;
        obs_rdata = bus.rsp_rdata;
        obs_sel   = bus.select;
        obs_mis   = bus.misalign;
        obs_berr  = bus.bus_err;
      end else if (bus.mem_valid) begin
        obs_busy++;
        if (first) begin
          first     = 0;
          obs_we    = bus.mem_we;
          obs_addr  = bus.mem_addr;
          obs_strb  = bus.mem_wstrb;
          obs_wdata = bus.mem_wdata;
        end else if (bus.mem_we !== obs_we || bus.mem_addr !== obs_addr ||
                     bus.mem_wstrb !== obs_strb || bus.mem_wdata !== obs_wdata) begin
          obs_unstable++;
        end
        if (obs_busy == ready_cyc) bus.mem_ready = 1'b1;
      end
    end
    check({name, ".rsp_seen"}, 32'(got_rsp), 32'd1);
    check({name, ".stable"}, obs_unstable, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1;
    check({name, ".pulse_end"}, {29'd0, bus.rsp_valid, bus.misalign, bus.bus_err}, 32'd0);
  endtask

  task automatic expect_rsp(input string name, input int busy, input int stall, input int lat,
                            input logic [31:0] rdata, input logic sel, input logic mis,
                            input logic berr);
    check({name, ".busy"}, busy == obs_busy ? 32'd1 : 32'(obs_busy) + 32'h100, 32'd1);
    check({name, ".stall"}, obs_stall, stall);
    check({name, ".latency"}, obs_lat, lat);
    check({name, ".rdata"}, obs_rdata, rdata);
    check({name, ".flags"}, {29'd0, obs_sel, obs_mis, obs_berr}, {29'd0, sel, mis, berr});
  endtask

  task automatic expect_bus(input string name, input logic we, input logic [31:0] addr,
                            input logic [3:0] strb, input logic [31:0] wdata);
    check({name, ".we"}, 32'(obs_we), 32'(we));
    check({name, ".addr"}, obs_addr, addr);
    check({name, ".strb"}, 32'(obs_strb), 32'(strb));
    if (we) check({name, ".wdata"}, obs_wdata, wdata);
  endtask

  int pulses;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ctrl", {26'd0, bus.mem_valid, bus.stall, bus.rsp_valid, bus.select,
                         bus.misalign, bus.bus_err}, 32'd0);
    check("reset.rdata", bus.rsp_rdata, 32'd0);
    check("reset.strb", 32'(bus.mem_wstrb), 32'd0);
    rst = 1'b0;

    run_req("lw", 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    expect_rsp("lw", 1, 2, 2, 32'hDEADBEEF, 1, 0, 0);
    expect_bus("lw", 0, 32'h100, 4'b0000, 32'h0);

    run_req("lb", 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF7F01, 1);
    expect_rsp("lb", 1, 2, 2, 32'hFFFFFF80, 1, 0, 0);
    run_req("lbu", 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF7F01, 1);
    expect_rsp("lbu", 1, 2, 2, 32'h00000080, 1, 0, 0);
    run_req("lh", 1'b0, F3_H, 32'h102, 32'h0, 32'h80FF7F01, 1);
    expect_rsp("lh", 1, 2, 2, 32'hFFFF80FF, 1, 0, 0);
    run_req("lhu", 1'b0, F3_HU, 32'h100, 32'h0, 32'h80FF7F01, 1);
    expect_rsp("lhu", 1, 2, 2, 32'h00007F01, 1, 0, 0);
    run_req("lw_wait", 1'b0, F3_W, 32'h104, 32'h0, 32'h01234567, 3);
    expect_rsp("lw_wait", 3, 4, 4, 32'h01234567, 1, 0, 0);

    run_req("sh", 1'b1, F3_H, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 1);
    expect_rsp("sh", 1, 2, 2, 32'h0, 0, 0, 0);
    expect_bus("sh", 1, 32'h100, 4'b1100, 32'hABCDABCD);
    run_req("sw", 1'b1, F3_W, 32'h008, 32'h11223344, 32'h0, 1);
    expect_bus("sw", 1, 32'h008, 4'b1111, 32'h11223344);

    run_req("lw_mis", 1'b0, F3_W, 32'h101, 32'h0, 32'h0, 1);
    expect_rsp("lw_mis", 0, 1, 1, 32'h0, 0, 1, 0);
    run_req("lh_mis", 1'b0, F3_H, 32'h103, 32'h0, 32'h0, 1);
    expect_rsp("lh_mis", 0, 1, 1, 32'h0, 0, 1, 0);
    run_req("ld_ill", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 1);
    expect_rsp("ld_ill", 0, 1, 1, 32'h0, 0, 0, 1);
    run_req("st_ill", 1'b1, F3_BU, 32'h100, 32'h0, 32'h0, 1);
    expect_rsp("st_ill", 0, 1, 1, 32'h0, 0, 0, 1);

    run_req("tmo", 1'b0, F3_W, 32'h200, 32'h0, 32'hCAFEF00D, 0);
    expect_rsp("tmo", 4, 5, 5, 32'h0, 0, 0, 1);
    run_req("tmo_edge", 1'b0, F3_W, 32'h200, 32'h0, 32'hCAFEF00D, 4);
    expect_rsp("tmo_edge", 4, 5, 5, 32'hCAFEF00D, 1, 0, 0);

    // reset during the second BUSY cycle; the pipeline flush drops req_valid
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h300;
    bus.mem_ready  = 1'b0;
    @(posedge clk); #1;
    check("rst.busy1", 32'(bus.mem_valid), 32'd1);
    @(posedge clk); #1;
    check("rst.busy2", 32'(bus.mem_valid), 32'd1);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst.drop", {29'd0, bus.mem_valid, bus.stall, bus.rsp_valid}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) pulses++;
    end
    check("rst.no_rsp", pulses, 0);

    run_req("sb", 1'b1, F3_B, 32'h001, 32'h000000A5, 32'h0, 1);
    expect_rsp("sb", 1, 2, 2, 32'h0, 0, 0, 0);
    expect_bus("sb", 1, 32'h000, 4'b0010, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
